// File: rtl/predicate_writeback_queue_if.sv
// Bundle between the compare lanes, the predicate register write port and issue hazard logic.
// The queue is the slave; the producer/consumer side is the master.
interface predicate_writeback_queue_if #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 6,
    parameter int WARP_W = 4,
    parameter int DEPTH  = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [WARP_W-1:0]       in_warp;
    logic [ADDR_W-1:0]       in_addr;
    logic [LANES-1:0]        in_mask;
    logic [LANES-1:0]        in_data;
    logic                    rd_req;
    logic [LANES-1:0]        pr_write_en;
    logic [ADDR_W-1:0]       pr_waddr;
    logic [LANES-1:0]        pr_wdata;
    logic [WARP_W-1:0]       pr_warp_sel;
    logic [WARP_W-1:0]       hz_warp;
    logic [ADDR_W-1:0]       hz_addr;
    logic                    hz_hit;
    logic [$clog2(DEPTH):0]  occupancy;

    modport master (
        output in_valid, in_warp, in_addr, in_mask, in_data, rd_req, hz_warp, hz_addr,
        input  in_ready, pr_write_en, pr_waddr, pr_wdata, pr_warp_sel, hz_hit, occupancy
    );

    modport slave (
        input  in_valid, in_warp, in_addr, in_mask, in_data, rd_req, hz_warp, hz_addr,
        output in_ready, pr_write_en, pr_waddr, pr_wdata, pr_warp_sel, hz_hit, occupancy
    );
endinterface

// File: rtl/predicate_writeback_queue.sv
// FIFO of per-warp predicate results drained one entry per cycle into the predicate register
// write port, yielding to the read side and answering pending-write hazard queries.
module predicate_writeback_queue #(
    parameter int LANES  = 16,
    parameter int ADDR_W = 6,
    parameter int WARP_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic clk,
    input  logic rst,
    predicate_writeback_queue_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [WARP_W-1:0] warp;
        logic [ADDR_W-1:0] addr;
        logic [LANES-1:0]  mask;
        logic [LANES-1:0]  data;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  count;
    logic              live;
    logic              push;
    logic              pop;
    logic              hit;
    logic [IDX_W-1:0]  off;

    logic [LANES-1:0]  pr_en_q;
    logic [ADDR_W-1:0] pr_addr_q;
    logic [LANES-1:0]  pr_data_q;
    logic [WARP_W-1:0] pr_warp_q;

    // Wrap bit on each pointer distinguishes full from empty without a separate flag.
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[IDX_W-1:0]];

    // live holds in_ready low during reset and for the first edge after release.
    assign bus.in_ready  = live && (count < PTR_W'(DEPTH));
    assign bus.occupancy = count;

    // Zero-mask results complete the handshake but are never stored.
    assign push = bus.in_valid && bus.in_ready && (|bus.in_mask);
    assign pop  = (count != '0) && !bus.rd_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pr_en_q   <= '0;
            pr_addr_q <= '0;
            pr_data_q <= '0;
            pr_warp_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so ordering
            // between always_ff blocks never changes behaviour.
            live <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                pr_en_q   <= head.mask;
                pr_addr_q <= head.addr;
                pr_data_q <= head.data;
                pr_warp_q <= head.warp;
            end else begin
                pr_en_q <= '0;
            end
        end
    end

    // NOTE: storage is deliberately left out of reset; clearing the pointers already empties the
    // queue, and validity of each slot is derived from the pointers, never from its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[IDX_W-1:0]] <= '{warp: bus.in_warp, addr: bus.in_addr,
                                             mask: bus.in_mask, data: bus.in_data};
    end

    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch can be inferred.
        off = '0;
        hit = (|pr_en_q) && (pr_warp_q == bus.hz_warp) && (pr_addr_q == bus.hz_addr);
        for (int i = 0; i < DEPTH; i++) begin
            off = IDX_W'(i) - rd_ptr[IDX_W-1:0];
            if (({1'b0, off} < count) && (mem[i].warp == bus.hz_warp) && (mem[i].addr == bus.hz_addr))
                hit = 1'b1;
        end
    end

    assign bus.hz_hit      = hit;
    assign bus.pr_write_en = pr_en_q;
    assign bus.pr_waddr    = pr_addr_q;
    assign bus.pr_wdata    = pr_data_q;
    assign bus.pr_warp_sel = pr_warp_q;
endmodule
